// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
//   arb_state_e : arbiter FSM encoding
//   NOP_INSN    : instruction returned to IF when a fetch times out
//   mem_cmd_t   : registered command presented to the memory
package imem_dmem_arbiter_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_cmd_t;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the IF/MEM stages, the arbiter and the unified memory.
//   slave  : arbiter view (takes fetch/data requests, drives memory)
//   master : environment view (pipeline stages plus memory model)
interface imem_dmem_arbiter_if;
    import imem_dmem_arbiter_pkg::*;

    // fetch port
    logic              if_req;
    logic [XLEN-1:0]   if_addr;
    logic              if_flush;
    logic [XLEN-1:0]   if_rdata;
    logic              if_valid;
    logic              if_stall;
    // load/store port
    logic              dm_req;
    logic              dm_we;
    logic [XLEN-1:0]   dm_addr;
    logic [XLEN-1:0]   dm_wdata;
    logic [STRB_W-1:0] dm_wstrb;
    logic [XLEN-1:0]   dm_rdata;
    logic              dm_valid;
    logic              dm_stall;
    // memory port
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;
    logic              bus_err;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_valid, if_stall,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output dm_rdata, dm_valid, dm_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        output bus_err
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_valid, if_stall,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  dm_rdata, dm_valid, dm_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        input  bus_err
    );
endinterface

// File: rtl/arb_timeout_counter.sv
// Loadable up-counter that saturates at LIMIT and flags terminal count.
//   load_i/load_val_i : synchronous load (wins over en_i)
//   en_i              : count enable
//   tc_o              : counter equals LIMIT
module arb_timeout_counter #(
    parameter int unsigned W     = 7,
    parameter int unsigned LIMIT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == W'(LIMIT));

    // next count: load, else step until terminal count
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the IF fetch port and the MEM load/store port onto one
// single-port memory. Data has priority unless a waiting fetch has been
// passed over STARVE_LIMIT times. Accesses that see no mem_ready within
// TIMEOUT_CYCLES are aborted and flag bus_err.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch, data and memory signals (slave modport)
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input logic                clk,
    input logic                rst_n,
    imem_dmem_arbiter_if.slave bus
);
    localparam int unsigned     SC_W       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    arb_state_e      state_q, state_d;
    logic [SC_W-1:0] starve_q, starve_d;
    logic            discard_q, discard_d;
    logic            mem_req_q, mem_req_d;
    mem_cmd_t        cmd_q, cmd_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;
    logic            if_valid_q, if_valid_d;
    logic            dm_valid_q, dm_valid_d;
    logic            bus_err_q, bus_err_d;
    logic            tmo_load_c, tmo_en_c, tmo_tc_c;

    // loaded with 1 at grant so terminal count lands on the last allowed busy cycle
    assign tmo_en_c = (state_q != IDLE);

    arb_timeout_counter #(
        .W     (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmo_load_c),
        .load_val_i (CNT_W'(1)),
        .en_i       (tmo_en_c),
        .tc_o       (tmo_tc_c)
    );

    // arbitration, completion and timeout
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        discard_d  = discard_q;
        mem_req_d  = mem_req_q;
        cmd_d      = cmd_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        bus_err_d  = bus_err_q;
        tmo_load_c = 1'b0;

        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (!bus.if_req) starve_d = '0;
                // hold off while a completion pulse is out: its requester still shows the old request
                if (!if_valid_q && !dm_valid_q) begin
                    if (bus.dm_req && !(bus.if_req && starve_q == STARVE_MAX)) begin
                        state_d    = DM_BUSY;
                        mem_req_d  = 1'b1;
                        tmo_load_c = 1'b1;
                        cmd_d      = '{we: bus.dm_we, addr: bus.dm_addr,
                                       wdata: bus.dm_wdata, wstrb: bus.dm_wstrb};
                        // cannot pass STARVE_MAX: at the limit the fetch wins instead
                        if (bus.if_req) starve_d = starve_q + SC_W'(1);
                    end else if (bus.if_req) begin
                        state_d    = IF_BUSY;
                        mem_req_d  = 1'b1;
                        tmo_load_c = 1'b1;
                        cmd_d      = '{we: 1'b0, addr: bus.if_addr, wdata: '0, wstrb: '0};
                        starve_d   = '0;
                    end
                end
            end

            IF_BUSY: begin
                discard_d = discard_q | bus.if_flush;
                if (bus.mem_ready || tmo_tc_c) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    if (!bus.mem_ready) bus_err_d = 1'b1;
                    // a flushed fetch finishes on the memory side but never reaches IF
                    if (!(discard_q || bus.if_flush)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.mem_ready ? bus.mem_rdata : NOP_INSN;
                    end
                end
            end

            DM_BUSY: begin
                if (bus.mem_ready || tmo_tc_c) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    dm_valid_d = 1'b1;
                    dm_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                    if (!bus.mem_ready) bus_err_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            discard_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            cmd_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            discard_q  <= discard_d;
            mem_req_q  <= mem_req_d;
            cmd_q      <= cmd_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = cmd_q.we;
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_wdata = cmd_q.wdata;
    assign bus.mem_wstrb = cmd_q.wstrb;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.bus_err   = bus_err_q;

    // stalls follow the raw requests so they rise in the request cycle itself
    assign bus.if_stall  = bus.if_req & ~if_valid_q;
    assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;
endmodule
